// File: rtl/load_store_unit.sv
// load_store_unit
//   Bridges the MEM pipeline stage and a single-port, word-wide data memory.
//   It takes one load/store request at a time:
//     - loads read one word and return the selected lane, sign- or zero-extended;
//     - SW writes the full word directly;
//     - SB/SH do a read-modify-write, replacing only the target lane;
//     - misaligned or out-of-range requests are flagged without touching memory.
//   Each request produces exactly one resp_valid pulse.
//
// Ports
//   clk, rst_n             rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready    request handshake; req_ready is high only in IDLE
//   req_op                 000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU,
//                          101 SB, 110 SH, 111 SW
//   req_addr, req_wdata    byte address and store data
//   resp_valid             one-cycle response pulse
//   resp_err               error flag, qualified by resp_valid
//   resp_rdata             extended load data; 0 for stores and errors
//   dm_read, dm_write      memory strobes, decoded from the registered state
//   dm_addr                word-aligned address of the current access
//   dm_wdata               full word to write
//   dm_rdata               combinational read data from the memory
module load_store_unit #(
  parameter int unsigned MEM_BYTES   = 4096,
  parameter bit          CHECK_RANGE = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        dm_read,
  output logic        dm_write,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata
);

  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LW  = 3'b010;
  localparam logic [2:0] OP_LBU = 3'b011;
  localparam logic [2:0] OP_LHU = 3'b100;
  localparam logic [2:0] OP_SB  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SW  = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_RD,
    WRITE,
    RESP
  } state_t;

  state_t      state;
  logic [2:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] merge_q;
  logic [31:0] rdata_q;
  logic        err_q;

  // Accept-time error detection on the incoming request
  logic half_op;
  logic word_op;
  logic misaligned;
  logic out_of_range;
  logic req_err;

  always_comb begin
    half_op      = (req_op == OP_LH) || (req_op == OP_LHU) || (req_op == OP_SH);
    word_op      = (req_op == OP_LW) || (req_op == OP_SW);
    misaligned   = (half_op && req_addr[0]) || (word_op && (req_addr[1:0] != 2'b00));
    out_of_range = CHECK_RANGE && (req_addr >= MEM_BYTES);
    req_err      = misaligned || out_of_range;
  end

  // Lane extraction for loads and lane merge for sub-word stores
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic [31:0] merged;

  always_comb begin
    ld_byte = '0;
    case (addr_q[1:0])
      2'd0: ld_byte = dm_rdata[7:0];
      2'd1: ld_byte = dm_rdata[15:8];
      2'd2: ld_byte = dm_rdata[23:16];
      2'd3: ld_byte = dm_rdata[31:24];
      default: ld_byte = '0;
    endcase
    ld_half = addr_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];

    ld_data = '0;
    case (op_q)
      OP_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      OP_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
      OP_LW:   ld_data = dm_rdata;
      OP_LBU:  ld_data = {24'd0, ld_byte};
      OP_LHU:  ld_data = {16'd0, ld_half};
      default: ld_data = '0;
    endcase

    merged = dm_rdata;
    if (op_q == OP_SB) begin
      case (addr_q[1:0])
        2'd0: merged[7:0]   = wdata_q[7:0];
        2'd1: merged[15:8]  = wdata_q[7:0];
        2'd2: merged[23:16] = wdata_q[7:0];
        2'd3: merged[31:24] = wdata_q[7:0];
        default: merged = dm_rdata;
      endcase
    end else if (addr_q[1]) begin
      merged[31:16] = wdata_q[15:0];
    end else begin
      merged[15:0] = wdata_q[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q    <= req_op;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            rdata_q <= '0;
            err_q   <= req_err;
            if (req_err)                              state <= RESP;
            else if (req_op <= OP_LHU)                state <= LOAD;
            else if (req_op == OP_SW)                 state <= WRITE;
            else                                      state <= RMW_RD;
          end
        end
        LOAD: begin
          rdata_q <= ld_data;
          state   <= RESP;
        end
        RMW_RD: begin
          merge_q <= merged;
          state   <= WRITE;
        end
        WRITE:   state <= RESP;
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready  = (state == IDLE);
  assign dm_read    = (state == LOAD) || (state == RMW_RD);
  assign dm_write   = (state == WRITE);
  assign dm_addr    = {addr_q[31:2], 2'b00};
  assign dm_wdata   = (state == WRITE) ? ((op_q == OP_SW) ? wdata_q : merge_q) : '0;
  assign resp_valid = (state == RESP);
  assign resp_err   = (state == RESP) && err_q;
  assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        dm_read;
  logic        dm_write;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;

  load_store_unit #(.MEM_BYTES(4096), .CHECK_RANGE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;
  longint      cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input int unsigned i);
    return (i * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  // Memory the DUT talks to
  logic [31:0] tmem [1024];
  logic        inited = 1'b0;
  assign dm_rdata = tmem[dm_addr[11:2]];

  always @(posedge clk) begin
    if (!inited) begin
      for (int i = 0; i < 1024; i++) tmem[i] <= init_word(i);
      inited <= 1'b1;
    end else if (dm_write) begin
      tmem[dm_addr[11:2]] <= dm_wdata;
    end
  end

  // Reference: byte-addressed memory and per-request expectations
  logic [7:0] rmem [4096];

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int unsigned lat;
    int unsigned nrd;
    int unsigned nwr;
    logic [31:0] waddr;
    logic [31:0] wword;
    longint      acc;
  } exp_t;

  exp_t q[$];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic exp_t model(input logic [2:0] op, input logic [31:0] addr,
                                 input logic [31:0] wd);
    exp_t e;
    int unsigned a, b;
    logic half, word;
    half    = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    word    = (op == 3'd2) || (op == 3'd7);
    e.err   = (half && addr[0]) || (word && addr[1:0] != 2'b00) || (addr >= 32'd4096);
    e.rdata = '0; e.lat = 1; e.nrd = 0; e.nwr = 0; e.wword = '0; e.acc = 0;
    e.waddr = {addr[31:2], 2'b00};
    if (!e.err) begin
      a = int'(addr[11:0]);
      b = a & ~3;
      case (op)
        3'd0: e.rdata = {{24{rmem[a][7]}}, rmem[a]};
        3'd1: e.rdata = {{16{rmem[a+1][7]}}, rmem[a+1], rmem[a]};
        3'd2: e.rdata = {rmem[a+3], rmem[a+2], rmem[a+1], rmem[a]};
        3'd3: e.rdata = {24'd0, rmem[a]};
        3'd4: e.rdata = {16'd0, rmem[a+1], rmem[a]};
        3'd5: rmem[a] = wd[7:0];
        3'd6: begin rmem[a] = wd[7:0]; rmem[a+1] = wd[15:8]; end
        default: begin
          rmem[a] = wd[7:0];   rmem[a+1] = wd[15:8];
          rmem[a+2] = wd[23:16]; rmem[a+3] = wd[31:24];
        end
      endcase
      if (op <= 3'd4) begin
        e.lat = 2; e.nrd = 1;
      end else begin
        e.wword = {rmem[b+3], rmem[b+2], rmem[b+1], rmem[b]};
        e.nwr   = 1;
        e.nrd   = (op == 3'd7) ? 0 : 1;
        e.lat   = (op == 3'd7) ? 2 : 3;
      end
    end
    return e;
  endfunction

  // Present a request and hold it until accepted; leaves req_valid high
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd);
    int unsigned n = 0;
    exp_t e;
    req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = wd;
    @(negedge clk);
    while (!req_ready && n < 100) begin n++; @(negedge clk); end
    if (!req_ready) begin
      bad++; total++;
      $display("FAIL accept_timeout actual=ready0 required=ready1");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "request never accepted");
    end
    e = model(op, a, wd);
    e.acc = cyc;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int unsigned n);
    req_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: checks every memory access and every response against the queue head
  int unsigned rd_cnt = 0;
  int unsigned wr_cnt = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      rd_cnt = 0; wr_cnt = 0;
    end else begin
      if (dm_read && dm_write) begin
        total++; bad++;
        $display("FAIL dm_both actual=read1_write1 required=exclusive");
      end
      if (dm_read || dm_write) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL dm_spurious actual=access required=none");
        end else begin
          chk("dm_addr", dm_addr, q[0].waddr);
          if (dm_write) chk("dm_wdata", dm_wdata, q[0].wword);
        end
      end
      if (dm_read)  rd_cnt++;
      if (dm_write) wr_cnt++;
      if (resp_valid) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL resp_spurious actual=resp_valid1 required=0");
        end else begin
          e = q.pop_front();
          chk("resp_err", 32'(resp_err), 32'(e.err));
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("latency", 32'(cyc - e.acc), e.lat);
          chk("read_cycles", rd_cnt, e.nrd);
          chk("write_cycles", wr_cnt, e.nwr);
        end
        rd_cnt = 0; wr_cnt = 0;
      end
    end
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] a;
    int unsigned r, n;

    for (int i = 0; i < 1024; i++) begin
      a = init_word(i);
      for (int k = 0; k < 4; k++) rmem[4*i+k] = a[8*k +: 8];
    end

    #1;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_dm_write", 32'(dm_write), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", 32'(req_ready), 32'd1);

    // Word store then load
    issue(3'd7, 32'h10, 32'hDEADBEEF);
    issue(3'd2, 32'h10, 32'h0);
    idle(2);

    // Sub-word loads
    issue(3'd7, 32'h20, 32'h8081F0F1);
    issue(3'd0, 32'h21, 32'h0);
    issue(3'd3, 32'h23, 32'h0);
    issue(3'd1, 32'h22, 32'h0);
    issue(3'd4, 32'h20, 32'h0);
    idle(1);

    // Read-modify-write
    issue(3'd7, 32'h30, 32'h11223344);
    issue(3'd5, 32'h31, 32'hFFFFFFAA);
    issue(3'd6, 32'h32, 32'h1234BEEF);
    issue(3'd2, 32'h30, 32'h0);
    idle(1);

    // Errors
    issue(3'd2, 32'h05, 32'h0);
    issue(3'd6, 32'h07, 32'hCAFE);
    issue(3'd2, 32'h1000, 32'h0);
    issue(3'd5, 32'hFFFFFFFF, 32'h55);
    idle(3);

    // Randomized traffic, mixing back-to-back bursts and idle gaps
    for (int t = 0; t < 300; t++) begin
      op = 3'($urandom_range(0, 7));
      r  = $urandom_range(0, 15);
      if (r == 0) a = $urandom | 32'h1000;
      else begin
        a = 32'($urandom_range(0, 4095));
        if (r < 12) begin
          if (op == 3'd1 || op == 3'd4 || op == 3'd6) a[0] = 1'b0;
          if (op == 3'd2 || op == 3'd7) a[1:0] = 2'b00;
        end
      end
      issue(op, a, $urandom);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 2));
    end
    idle(4);

    // Reset in the middle of a load
    issue(3'd2, 32'h10, 32'h0);
    req_valid = 1'b0;
    chk("midload_dm_read", 32'(dm_read), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_dm_read", 32'(dm_read), 32'd0);
    chk("rst_dm_write", 32'(dm_write), 32'd0);
    chk("rst_dm_addr", dm_addr, 32'd0);
    chk("rst_dm_wdata", dm_wdata, 32'd0);
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_midload_reset", 32'(req_ready), 32'd1);
    repeat (4) @(posedge clk);
    #1;

    // Traffic continues normally after reset
    issue(3'd7, 32'h40, 32'h0BADF00D);
    issue(3'd6, 32'h42, 32'h00007777);
    issue(3'd2, 32'h40, 32'h0);
    idle(1);

    n = 0;
    while (q.size() != 0 && n < 50) begin n++; @(negedge clk); end
    if (q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain actual=%0d pending required=0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
